rx_ram_arbiter: RTL and testbench
=================================

# rx_ram_arbiter

Two-master Avalon-MM arbiter sharing the single-port 1K×32 packet RAM between the receive-packet writer (master 0) and the CPU/host reader (master 1). Sits between `receive_packet` (its `ram_*` master port) and the on-chip RAM slave. Grants are round-robin with a per-grant transfer cap, and master 0 can lock the bus for a whole packet. Switching happens only between transfers, so the Avalon semantics of each master are never broken.

## Interface
- `MAX_BURST`, default 16: max consecutive completed transfers for one master while the other is requesting (range 1..255).
- `clk_original`  in  1  sole clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `m0_addr` / `m1_addr`  in  10  word address.
- `m0_chipselect` / `m1_chipselect`  in  1  transfer request.
- `m0_write` / `m1_write`  in  1  1 = write, 0 = read.
- `m0_writedata` / `m1_writedata`  in  32  write data.
- `m0_byteenable` / `m1_byteenable`  in  4  byte enables.
- `m0_lock`  in  1  master 0 holds the grant while high (packet atomicity).
- `m0_readdata` / `m1_readdata`  out  32  read data, valid in the cycle the transfer completes.
- `m0_waitrequest` / `m1_waitrequest`  out  1  stall.
- `ram_addr`  out  10, `ram_chipselect`  out  1, `ram_write`  out  1, `ram_writedata`  out  32, `ram_byteenable`  out  4: slave side.
- `ram_readdata`  in  32, `ram_waitrequest`  in  1: slave side.
- `grant`  out  2  one-hot current owner (status).

## Operation
- States: `G0` (master 0 owns RAM) and `G1` (master 1 owns RAM). Reset state is `G0`; the bus stays parked on the last owner.
- `en_q` register: reset 0, set to 1 one cycle after reset release.
- Slave outputs are muxed combinationally from the owner. `ram_chipselect` = owner chipselect & `en_q`. `ram_write` is gated the same way.
- Owner `mX_waitrequest` = `ram_waitrequest` | !`en_q`. Non-owner waitrequest = 1.
- `readdata` of both masters = `ram_readdata`. Only the owner's copy is meaningful.
- Completion: `ram_chipselect` & !`ram_waitrequest`.
- Owner is idle: owner chipselect = 0.
- `burst_cnt`:
  - cleared on each ownership change;
  - +1 on each completion;
  - saturates at `MAX_BURST`.
- Switch to the other master at the clock edge when the other's chipselect = 1, lock is not held, and either:
  - the owner is idle, or
  - completion occurs with `burst_cnt` ≥ `MAX_BURST`−1.
- Lock held: state = `G0` & `m0_lock`. A lock raised while in `G1` has no effect until master 0 is granted.
- The grant never changes while owner chipselect = 1 and `ram_waitrequest` = 1 (mid-transfer).
- Both masters requesting from a parked, idle owner: the other master wins. This is round-robin.

## Timing
- Arbitration adds zero latency for the owner. Its transfer reaches the slave in the same cycle.
- Non-owner latency: grant arrives at the edge after the switch condition. The request reaches the slave one cycle later at the earliest.
- Reset values: `grant` = 01, `ram_chipselect` = 0, `ram_write` = 0, both waitrequests = 1, `burst_cnt` = 0.
- Reset mid-transfer: the slave request drops immediately (asynchronous gate via `en_q`). The state returns to `G0`.
- Lock released in the same cycle as a completion: a switch is permitted at that edge.

## Configuration
- `RX_RAM_ARB_LOCK_EN` defined: `m0_lock` behaves as specified.
- Undefined: `m0_lock` is ignored, and master 0 is subject to the `MAX_BURST` cap like master 1.

## Structure
- Package `rx_ram_pkg`:
  - `RAM_AW` = 10, `RAM_DW` = 32, `RAM_BEW` = 4;
  - typedef `arb_state_t` {`G0`, `G1`};
  - typedef `ram_req_t` struct {addr, cs, write, wdata, be}, shared with `receive_packet` and future RAM clients.
- No sub-module. This is a single flat module: state register, counter and output mux.

## Test plan
- Reset release with `m0_chipselect` = 1 → `ram_chipselect` = 0 in cycle 0. The first slave request appears in the cycle after reset release, and `grant` = 01.
- M0 idle, M1 reads address 0x3FF (RAM returns 0xDEADBEEF, waitrequest 0) → `grant` = 10 after 1 edge. `m1_readdata` = 0xDEADBEEF in the completion cycle.
- Both masters stream writes continuously, `MAX_BURST` = 4, no lock → ownership alternates after every 4 completions: 4 M0, 4 M1, 4 M0.
- `RX_RAM_ARB_LOCK_EN` defined, `m0_lock` = 1 for 64 writes, M1 requesting throughout → M1 waitrequest is stuck at 1 for all 64 writes. M1 is granted at the edge after the lock drops and the last completion. Macro undefined → M1 is granted after 16 writes.
- Slave holds waitrequest for 5 cycles on an M0 write while M1 requests → `grant` stays 01 until the completion cycle, then switches. `ram_addr` and `ram_writedata` are stable throughout.
- `rst_n` asserted during a stalled M1 transfer → `ram_chipselect` drops immediately and `grant` = 01. After release there are no spurious completions on M1.

Source files
------------

// File: rtl/rx_ram_pkg.sv
// Shared types and constants for the packet-RAM clients and the rx_ram_arbiter.
package rx_ram_pkg;

    localparam int unsigned RAM_AW  = 10;
    localparam int unsigned RAM_DW  = 32;
    localparam int unsigned RAM_BEW = 4;

    typedef enum logic {
        G0 = 1'b0,
        G1 = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [RAM_AW-1:0]  addr;
        logic               cs;
        logic               write;
        logic [RAM_DW-1:0]  wdata;
        logic [RAM_BEW-1:0] be;
    } ram_req_t;

endpackage

// File: rtl/rx_ram_arbiter.sv
// Round-robin two-master Avalon-MM arbiter for the 1Kx32 packet RAM with a per-grant cap.
// Optional packet lock for master 0 is enabled by defining RX_RAM_ARB_LOCK_EN.
module rx_ram_arbiter
    import rx_ram_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic               clk_original,
    input  logic               rst_n,

    input  logic [RAM_AW-1:0]  m0_addr,
    input  logic               m0_chipselect,
    input  logic               m0_write,
    input  logic [RAM_DW-1:0]  m0_writedata,
    input  logic [RAM_BEW-1:0] m0_byteenable,
    input  logic               m0_lock,
    output logic [RAM_DW-1:0]  m0_readdata,
    output logic               m0_waitrequest,

    input  logic [RAM_AW-1:0]  m1_addr,
    input  logic               m1_chipselect,
    input  logic               m1_write,
    input  logic [RAM_DW-1:0]  m1_writedata,
    input  logic [RAM_BEW-1:0] m1_byteenable,
    output logic [RAM_DW-1:0]  m1_readdata,
    output logic               m1_waitrequest,

    output logic [RAM_AW-1:0]  ram_addr,
    output logic               ram_chipselect,
    output logic               ram_write,
    output logic [RAM_DW-1:0]  ram_writedata,
    output logic [RAM_BEW-1:0] ram_byteenable,
    input  logic [RAM_DW-1:0]  ram_readdata,
    input  logic               ram_waitrequest,

    output logic [1:0]         grant,
    output arb_state_t         dbg_state,
    output logic [7:0]         dbg_burst_cnt
);

    // Handshake: a transfer completes in the cycle ram_chipselect=1 and ram_waitrequest=0;
    // a master must hold its request stable while its waitrequest is 1.

    localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t state_q, state_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       en_q;

    ram_req_t   m0_req, m1_req, own_req;
    logic       other_cs;
    logic       owner_idle;
    logic       completion;
    logic       lock_held;
    logic       do_switch;

    always_comb begin
        m0_req = '{addr: m0_addr, cs: m0_chipselect, write: m0_write,
                   wdata: m0_writedata, be: m0_byteenable};
        m1_req = '{addr: m1_addr, cs: m1_chipselect, write: m1_write,
                   wdata: m1_writedata, be: m1_byteenable};
    end

    assign own_req  = (state_q == G0) ? m0_req : m1_req;
    assign other_cs = (state_q == G0) ? m1_chipselect : m0_chipselect;

`ifdef RX_RAM_ARB_LOCK_EN
    assign lock_held = (state_q == G0) && m0_lock;
`else
    logic lock_unused;
    assign lock_unused = m0_lock;
    assign lock_held   = 1'b0;
`endif

    // en_q gates the slave request so an asserted reset drops it without waiting for a clock.
    always_ff @(posedge clk_original or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    assign ram_addr       = own_req.addr;
    assign ram_chipselect = own_req.cs & en_q;
    assign ram_write      = own_req.write & own_req.cs & en_q;
    assign ram_writedata  = own_req.wdata;
    assign ram_byteenable = own_req.be;

    assign m0_waitrequest = (state_q == G0) ? (ram_waitrequest | ~en_q) : 1'b1;
    assign m1_waitrequest = (state_q == G1) ? (ram_waitrequest | ~en_q) : 1'b1;
    assign m0_readdata    = ram_readdata;
    assign m1_readdata    = ram_readdata;

    assign completion = ram_chipselect & ~ram_waitrequest;
    assign owner_idle = ~own_req.cs;

    // A stalled owner is neither idle nor completing, so the grant cannot move mid-transfer.
    assign do_switch = other_cs && !lock_held &&
                       (owner_idle || (completion && (burst_cnt_q >= BURST_LAST)));

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        if (do_switch) begin
            state_d     = (state_q == G0) ? G1 : G0;
            burst_cnt_d = 8'd0;
        end else if (completion && (burst_cnt_q < BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_original or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= G0;
            burst_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign grant         = (state_q == G0) ? 2'b01 : 2'b10;
    assign dbg_state     = state_q;
    assign dbg_burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_rx_ram_arbiter.sv
// Directed bench for rx_ram_arbiter (MAX_BURST = 4): vector table plus multi-cycle sequences.
module tb_rx_ram_arbiter;
    import rx_ram_pkg::*;

    localparam int unsigned MB = 4;

    logic        clk_original = 1'b0;
    logic        rst_n;
    logic [9:0]  m0_addr, m1_addr;
    logic        m0_chipselect, m1_chipselect;
    logic        m0_write, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_lock;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [9:0]  ram_addr;
    logic        ram_chipselect, ram_write;
    logic [31:0] ram_writedata;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_readdata;
    logic        ram_waitrequest;
    logic [1:0]  grant;
    arb_state_t  dbg_state;
    logic [7:0]  dbg_burst_cnt;

    int tests = 0;
    int fails = 0;

    rx_ram_arbiter #(.MAX_BURST(MB)) dut (
        .clk_original   (clk_original),
        .rst_n          (rst_n),
        .m0_addr        (m0_addr),
        .m0_chipselect  (m0_chipselect),
        .m0_write       (m0_write),
        .m0_writedata   (m0_writedata),
        .m0_byteenable  (m0_byteenable),
        .m0_lock        (m0_lock),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_addr        (m1_addr),
        .m1_chipselect  (m1_chipselect),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_byteenable  (m1_byteenable),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .ram_addr       (ram_addr),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable),
        .ram_readdata   (ram_readdata),
        .ram_waitrequest(ram_waitrequest),
        .grant          (grant),
        .dbg_state      (dbg_state),
        .dbg_burst_cnt  (dbg_burst_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_original = ~clk_original;

    task automatic tick();
        @(posedge clk_original);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        m0_addr = '0; m0_chipselect = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = 4'hF;
        m1_addr = '0; m1_chipselect = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = 4'hF;
        m0_lock = 0; ram_readdata = '0; ram_waitrequest = 0;
    endtask

    // Reset with idle masters; returns #1 after the second edge following release (en_q = 1).
    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        m0_cs, m0_wr;
        logic [9:0]  m0_a;
        logic        m1_cs, m1_wr;
        logic [9:0]  m1_a;
        logic        rwait;
        logic [31:0] rdata;
        logic [1:0]  e_grant;
        logic        e_cs, e_wr;
        logic [9:0]  e_addr;
        logic        e_m0w, e_m1w;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(logic m0c, logic m0w, logic [9:0] m0a, logic m1c, logic m1w,
                                logic [9:0] m1a, logic rw, logic [31:0] rd, logic [1:0] eg,
                                logic ec, logic ew, logic [9:0] ea, logic e0, logic e1);
        vec_t v;
        v.m0_cs = m0c; v.m0_wr = m0w; v.m0_a = m0a;
        v.m1_cs = m1c; v.m1_wr = m1w; v.m1_a = m1a;
        v.rwait = rw;  v.rdata = rd;
        v.e_grant = eg; v.e_cs = ec; v.e_wr = ew; v.e_addr = ea; v.e_m0w = e0; v.e_m1w = e1;
        return v;
    endfunction

    // ---------------- scoreboard for burst alternation ----------------
    logic [0:0] exp_q[$];

    initial begin
        int cnt;
        int viol;
        int pops;
        bit done;
        logic [0:0] e;

        rst_n = 0;
        idle_inputs();

        // Reset values, then release with M0 already requesting.
        m0_chipselect = 1; m0_write = 1; m0_addr = 10'h011;
        tick();
        check("rst_grant", 32'(grant), 32'h1);
        check("rst_ram_cs", 32'(ram_chipselect), 32'h0);
        check("rst_ram_wr", 32'(ram_write), 32'h0);
        check("rst_m0_wait", 32'(m0_waitrequest), 32'h1);
        check("rst_m1_wait", 32'(m1_waitrequest), 32'h1);
        check("rst_burst", 32'(dbg_burst_cnt), 32'h0);
        tick();
        rst_n = 1;
        @(negedge clk_original);
        check("rel_c0_ram_cs", 32'(ram_chipselect), 32'h0);
        check("rel_c0_grant", 32'(grant), 32'h1);
        @(negedge clk_original);
        check("rel_c1_ram_cs", 32'(ram_chipselect), 32'h1);
        check("rel_c1_m0_wait", 32'(m0_waitrequest), 32'h0);
        check("rel_c1_addr", 32'(ram_addr), 32'h011);

        // Table: each row is one cycle, state carries over row to row.
        vecs[0] = mk(0,0,10'h000, 0,0,10'h000, 0,32'h0,        2'b01, 0,0,10'h000, 0,1);
        vecs[1] = mk(0,0,10'h000, 1,0,10'h3FF, 0,32'hDEADBEEF, 2'b01, 0,0,10'h000, 0,1);
        vecs[2] = mk(0,0,10'h000, 1,0,10'h3FF, 0,32'hDEADBEEF, 2'b10, 1,0,10'h3FF, 1,0);
        vecs[3] = mk(0,0,10'h000, 0,0,10'h000, 0,32'h0,        2'b10, 0,0,10'h000, 1,0);
        vecs[4] = mk(1,1,10'h005, 0,0,10'h000, 0,32'h0,        2'b10, 0,0,10'h000, 1,0);
        vecs[5] = mk(1,1,10'h005, 0,0,10'h000, 0,32'h0,        2'b01, 1,1,10'h005, 0,1);
        vecs[6] = mk(1,1,10'h006, 1,0,10'h010, 1,32'h0,        2'b01, 1,1,10'h006, 1,1);
        vecs[7] = mk(1,1,10'h006, 1,0,10'h010, 0,32'h0,        2'b01, 1,1,10'h006, 0,1);
        vecs[8] = mk(0,0,10'h000, 1,0,10'h010, 0,32'h0,        2'b01, 0,0,10'h000, 0,1);
        vecs[9] = mk(0,0,10'h000, 1,0,10'h010, 0,32'h12345678, 2'b10, 1,0,10'h010, 1,0);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            m0_chipselect = vecs[i].m0_cs; m0_write = vecs[i].m0_wr; m0_addr = vecs[i].m0_a;
            m1_chipselect = vecs[i].m1_cs; m1_write = vecs[i].m1_wr; m1_addr = vecs[i].m1_a;
            ram_waitrequest = vecs[i].rwait; ram_readdata = vecs[i].rdata;
            @(negedge clk_original);
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            check($sformatf("v%0d_ram_cs", i), 32'(ram_chipselect), 32'(vecs[i].e_cs));
            check($sformatf("v%0d_ram_wr", i), 32'(ram_write), 32'(vecs[i].e_wr));
            check($sformatf("v%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_m0_wait", i), 32'(m0_waitrequest), 32'(vecs[i].e_m0w));
            check($sformatf("v%0d_m1_wait", i), 32'(m1_waitrequest), 32'(vecs[i].e_m1w));
            check($sformatf("v%0d_m1_rdata", i), m1_readdata, vecs[i].rdata);
            tick();
        end

        // Both masters stream writes: 4 M0, 4 M1, 4 M0 completions.
        do_reset();
        for (int i = 0; i < 12; i++) exp_q.push_back((i / 4) % 2 == 1);
        m0_chipselect = 1; m0_write = 1; m0_addr = 10'h100;
        m1_chipselect = 1; m1_write = 1; m1_addr = 10'h200;
        pops = 0;
        for (int c = 0; c < 40 && pops < 12; c++) begin
            @(negedge clk_original);
            if (ram_chipselect && !ram_waitrequest) begin
                e = exp_q.pop_front();
                pops++;
                check($sformatf("rr_owner%0d", pops), 32'(grant), (e == 1'b1) ? 32'h2 : 32'h1);
            end
            tick();
        end
        check("rr_all_done", 32'(exp_q.size()), 32'h0);

        // Lock / cap: M1 requests throughout while M0 streams with lock raised.
        do_reset();
        m0_chipselect = 1; m0_write = 1; m0_addr = 10'h040;
        m1_chipselect = 1; m1_write = 0; m1_addr = 10'h041;
        cnt = 0; viol = 0; done = 0;
        for (int c = 0; c < 200; c++) begin
            m0_lock = (cnt < 63);
            @(negedge clk_original);
            if (grant == 2'b10) begin
                done = 1;
                break;
            end
            if (ram_chipselect && !ram_waitrequest) cnt++;
            if (m1_waitrequest !== 1'b1) viol++;
            tick();
        end
        check("lock_granted", 32'(done), 32'h1);
`ifdef RX_RAM_ARB_LOCK_EN
        check("lock_m0_count", 32'(cnt), 32'd64);
`else
        check("lock_m0_count", 32'(cnt), 32'(MB));
`endif
        check("lock_m1_stall", 32'(viol), 32'h0);
        m0_lock = 0;

        // Slave stalls an M0 write for 5 cycles while M1 requests; burst already at cap-1.
        do_reset();
        m0_chipselect = 1; m0_write = 1;
        for (int i = 0; i < 3; i++) begin
            m0_addr = 10'(i);
            tick();
        end
        check("stall_pre_burst", 32'(dbg_burst_cnt), 32'h3);
        m0_addr = 10'h1A5; m0_writedata = 32'hCAFE0001;
        m1_chipselect = 1; m1_write = 0; m1_addr = 10'h077;
        ram_waitrequest = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_original);
            check($sformatf("stall%0d_grant", i), 32'(grant), 32'h1);
            check($sformatf("stall%0d_addr", i), 32'(ram_addr), 32'h1A5);
            check($sformatf("stall%0d_wdata", i), ram_writedata, 32'hCAFE0001);
            check($sformatf("stall%0d_m0_wait", i), 32'(m0_waitrequest), 32'h1);
            tick();
        end
        ram_waitrequest = 0;
        @(negedge clk_original);
        check("stall_done_grant", 32'(grant), 32'h1);
        check("stall_done_m0_wait", 32'(m0_waitrequest), 32'h0);
        tick();
        m0_chipselect = 0;
        @(negedge clk_original);
        check("stall_switch_grant", 32'(grant), 32'h2);
        check("stall_switch_addr", 32'(ram_addr), 32'h077);
        tick();

        // Reset asserted while M1 is stalled.
        do_reset();
        m1_chipselect = 1; m1_write = 0; m1_addr = 10'h2AA;
        ram_waitrequest = 1;
        tick();
        @(negedge clk_original);
        check("mid_pre_grant", 32'(grant), 32'h2);
        check("mid_pre_ram_cs", 32'(ram_chipselect), 32'h1);
        check("mid_pre_m1_wait", 32'(m1_waitrequest), 32'h1);
        #2;
        rst_n = 0;
        #1;
        check("mid_rst_ram_cs", 32'(ram_chipselect), 32'h0);
        check("mid_rst_grant", 32'(grant), 32'h1);
        check("mid_rst_m1_wait", 32'(m1_waitrequest), 32'h1);
        tick();
        tick();
        ram_waitrequest = 0;
        rst_n = 1;
        @(negedge clk_original);
        check("mid_rel_m1_wait", 32'(m1_waitrequest), 32'h1);
        check("mid_rel_ram_cs", 32'(ram_chipselect), 32'h0);
        @(negedge clk_original);
        check("mid_rel2_grant", 32'(grant), 32'h2);
        check("mid_rel2_ram_cs", 32'(ram_chipselect), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
